fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage next-PC generator that sits directly upstream of the branch predictor. It holds the fetch PC and drives it to the predictor's `predict_pc`. It looks the PC up in a direct-mapped branch target buffer (BTB) and combines the BTB hit with the predictor's `prediction` to select the next fetch address. Execute-stage redirects on misprediction override everything except reset; execute also writes resolved taken-branch targets into the BTB.

## Interface
Parameters:
- `INST_BIT_WIDTH`, 32: PC and target width.
- `BTB_ENTRIES`, 64: number of BTB entries; must be a power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `stall`, input, 1: hold the fetch PC (downstream not ready).
- `redirect`, input, 1: execute-stage mispredict or redirect request.
- `redirect_pc`, input, INST_BIT_WIDTH: correct fetch address when `redirect`=1.
- `btb_update`, input, 1: write one BTB entry this cycle.
- `btb_update_pc`, input, INST_BIT_WIDTH: PC of the resolved taken branch.
- `btb_update_target`, input, INST_BIT_WIDTH: resolved branch target.
- `prediction`, input, 1: taken/not-taken from the branch predictor for the current `pc`.
- `pc`, output, INST_BIT_WIDTH: current fetch PC; also feeds the predictor's `predict_pc`.
- `pc_valid`, output, 1: `pc` is on the correct path and may be fetched.
- `pred_taken`, output, 1: fetch predicted a redirect to `pred_target`.
- `pred_target`, output, INST_BIT_WIDTH: BTB target for `pc`; 0 when there is no hit.

## Operation
- Definitions: `IDX_W = log2(BTB_ENTRIES)`; index = `pc[IDX_W+1:2]`; tag = `pc[INST_BIT_WIDTH-1:IDX_W+2]`. PC bits [1:0] are ignored for lookup.
- BTB entry fields: valid (1 bit), tag, target. On reset all valid bits are cleared. Tag and target contents are don't-care after reset.
- Lookup is combinational on the registered `pc`:
  - `btb_hit` = valid[index] && tag match.
  - `pred_target` = hit ? target : 0.
  - `pred_taken` = `btb_hit` && `prediction`.
- Next-PC priority:
  1. `reset` → `RESET_PC`.
  2. `redirect` → `redirect_pc`.
  3. `stall` → hold `pc`.
  4. `pred_taken` → `pred_target`.
  5. Otherwise → `pc + 4`, modulo 2^INST_BIT_WIDTH. 32'hFFFF_FFFC wraps to 0.
- `redirect` overrides `stall`. A redirect during a stall still loads `redirect_pc`.
- `pc_valid` = !`reset` && !`redirect`. The current `pc` is wrong-path in any cycle where `redirect` is asserted.
- BTB write: on a clock edge with `btb_update`=1, entry[index(`btb_update_pc`)] ← {valid=1, tag(`btb_update_pc`), `btb_update_target`}.
  - Any prior contents of that entry are overwritten; there are no replacement choices.
  - `btb_update` is independent of `stall` and `redirect`.
- BTB entries are never invalidated except by reset.

## Timing
- Reset values, asynchronous and immediate: `pc`=`RESET_PC`, `pc_valid`=0, all BTB valid bits=0, `pred_taken`=0, `pred_target`=0.
- First valid fetch is in the first cycle after `reset` deasserts: `pc`=`RESET_PC`, `pc_valid`=1.
- Next-PC latency is 1 cycle: the value selected in cycle N appears on `pc` in cycle N+1.
- Prediction path: `pc` → BTB read → `pred_taken`/`pred_target` → next-PC mux. All of it is combinational within one cycle. The `prediction` input must settle in the same cycle.
- BTB write/read collision: if a write and a lookup hit the same index in the same cycle, the lookup sees the old contents. The new entry is visible from the next cycle.
- Reset asserted mid-stall or mid-redirect: the async clear wins immediately. BTB valid bits clear in the same instant.
- `stall`=1 with `redirect`=0 holds `pc`. `pred_taken`/`pred_target` stay stable while the BTB and `prediction` are unchanged.

## Test plan
- **Reset and sequential fetch:** release reset with `RESET_PC`=0 and no other inputs → `pc` = 0x0, 0x4, 0x8, 0xC on successive cycles, `pc_valid`=1, `pred_taken`=0 throughout.
- **BTB hit, taken:** write {pc=0x10 → 0x200}, then fetch from 0x0 with `prediction`=1 → sequence 0x0, 0x4, 0x8, 0xC, 0x10, 0x200, 0x204. With `prediction`=0 instead, 0x10 is followed by 0x14.
- **Tag mismatch (aliasing):** write {0x10 → 0x200}; fetch 0x110 (same index for 64 entries, different tag) with `prediction`=1 → no hit, next `pc`=0x114, `pred_target`=0.
- **Stall and redirect priority:**
  - `stall` for 3 cycles at 0x8 → `pc` holds 0x8.
  - `redirect`=1 with `redirect_pc`=0x400 during the stall → `pc_valid`=0 that cycle, then `pc`=0x400.
- **Collision and overwrite:** at `pc`=0x10, write {0x10 → 0x300} in the same cycle → no hit that cycle. Later revisit of 0x10 → `pred_target`=0x300. Rewrite {0x10 → 0x500} → next hit gives 0x500.
- **Async reset mid-run:** assert `reset` between clock edges while `pc`=0x204 → `pc` becomes 0x0 without waiting for a clock edge. After release, the former BTB entry for 0x10 no longer hits.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC register with direct-mapped BTB and next-PC select
module fetch_pc_unit #(
  parameter int                        INST_BIT_WIDTH = 32,
  parameter int                        BTB_ENTRIES    = 64,
  parameter logic [INST_BIT_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect,
  input  logic [INST_BIT_WIDTH-1:0] redirect_pc,
  input  logic                      btb_update,
  input  logic [INST_BIT_WIDTH-1:0] btb_update_pc,
  input  logic [INST_BIT_WIDTH-1:0] btb_update_target,
  input  logic                      prediction,
  output logic [INST_BIT_WIDTH-1:0] pc,
  output logic                      pc_valid,
  output logic                      pred_taken,
  output logic [INST_BIT_WIDTH-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = INST_BIT_WIDTH - IDX_W - 2;

  logic [INST_BIT_WIDTH-1:0] r_pc;
  logic [BTB_ENTRIES-1:0]    r_valid;
  logic [TAG_W-1:0]          r_tag    [BTB_ENTRIES];
  logic [INST_BIT_WIDTH-1:0] r_target [BTB_ENTRIES];

  logic [IDX_W-1:0]          w_idx;
  logic [TAG_W-1:0]          w_tag;
  logic [IDX_W-1:0]          w_upd_idx;
  logic [TAG_W-1:0]          w_upd_tag;
  logic                      w_hit;
  logic [INST_BIT_WIDTH-1:0] w_next_pc;

  assign w_idx     = r_pc[IDX_W+1:2];
  assign w_tag     = r_pc[INST_BIT_WIDTH-1:IDX_W+2];
  assign w_upd_idx = btb_update_pc[IDX_W+1:2];
  assign w_upd_tag = btb_update_pc[INST_BIT_WIDTH-1:IDX_W+2];

  // Lookup reads the registered arrays, so a same-cycle write is seen next cycle.
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign pred_target = w_hit ? r_target[w_idx] : '0;
  assign pred_taken  = w_hit && prediction;
  assign pc          = r_pc;
  assign pc_valid    = !reset && !redirect;

  always_comb begin
    w_next_pc = r_pc + INST_BIT_WIDTH'(4);
    if (redirect)
      w_next_pc = redirect_pc;
    else if (stall)
      w_next_pc = r_pc;
    else if (pred_taken)
      w_next_pc = pred_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_valid <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (btb_update)
        r_valid[w_upd_idx] <= 1'b1;
    end
  end

  // Tag and target need no reset; the valid bits alone gate a hit.
  always_ff @(posedge clk) begin
    if (btb_update) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= btb_update_target;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized and directed checks of fetch_pc_unit against a reference model
module tb_fetch_pc_unit;

  localparam int          ENTRIES = 64;
  localparam logic [31:0] RST_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, btb_update, prediction;
  logic [31:0] redirect_pc, btb_update_pc, btb_update_target;
  logic [31:0] pc, pred_target;
  logic        pc_valid, pred_taken;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference BTB: slot number -> full PC of the branch written there, and its target.
  logic [31:0] m_br_pc  [int];
  logic [31:0] m_br_tgt [int];
  logic [31:0] m_pc;

  fetch_pc_unit #(
    .INST_BIT_WIDTH(32),
    .BTB_ENTRIES(ENTRIES),
    .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .btb_update(btb_update),
    .btb_update_pc(btb_update_pc), .btb_update_target(btb_update_target),
    .prediction(prediction), .pc(pc), .pc_valid(pc_valid),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % ENTRIES);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC;
    m_br_pc.delete();
    m_br_tgt.delete();
  endtask

  // Called at the negedge with inputs driven; checks this cycle, then advances one clock.
  task automatic cycle();
    logic        hit, taken;
    logic [31:0] tgt, nxt;
    int          s;
    #1;
    s     = slot(m_pc);
    // A hit means some resolved branch at the same word address lives in that slot.
    hit   = m_br_pc.exists(s) && ((m_br_pc[s] >> 2) == (m_pc >> 2));
    tgt   = hit ? m_br_tgt[s] : 32'h0;
    taken = hit && prediction;
    check("pc", pc, m_pc);
    check("pc_valid", {31'b0, pc_valid}, {31'b0, !redirect});
    check("pred_taken", {31'b0, pred_taken}, {31'b0, taken});
    check("pred_target", pred_target, tgt);
    if (redirect)   nxt = redirect_pc;
    else if (stall) nxt = m_pc;
    else if (taken) nxt = tgt;
    else            nxt = m_pc + 32'd4;
    @(posedge clk);
    m_pc = nxt;
    if (btb_update) begin
      m_br_pc[slot(btb_update_pc)]  = btb_update_pc;
      m_br_tgt[slot(btb_update_pc)] = btb_update_target;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic up, input logic [31:0] upc, input logic [31:0] utgt,
                       input logic pr);
    stall = st; redirect = rd; redirect_pc = rpc;
    btb_update = up; btb_update_pc = upc; btb_update_target = utgt;
    prediction = pr;
    cycle();
  endtask

  task automatic idle(input int n, input logic pr);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, pr);
  endtask

  initial begin
    reset = 1'b1; stall = 0; redirect = 0; redirect_pc = 0;
    btb_update = 0; btb_update_pc = 0; btb_update_target = 0; prediction = 0;
    model_reset();
    #12;
    check("rst_pc", pc, RST_PC);
    check("rst_pc_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    check("rst_pred_target", pred_target, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch, then BTB hit taken and not taken.
    idle(4, 0);
    drive(0, 1, 32'h0, 1, 32'h10, 32'h200, 0);
    idle(7, 1);
    drive(0, 1, 32'h0, 0, 0, 0, 0);
    idle(6, 0);

    // Aliasing: same slot as 0x10, different tag.
    drive(0, 1, 32'h110, 0, 0, 0, 1);
    idle(2, 1);

    // Stall holds; redirect during stall wins.
    drive(0, 1, 32'h8, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 32'h400, 0, 0, 0, 0);
    idle(2, 0);

    // Write/lookup collision on a fresh slot, revisit, overwrite.
    drive(0, 1, 32'h30, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 32'h30, 32'h300, 1);
    drive(0, 1, 32'h30, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 32'h30, 32'h500, 1);
    drive(0, 1, 32'h30, 0, 0, 0, 1);
    idle(1, 1);

    // Wrap at the top of the address space.
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    idle(2, 0);

    // Async reset mid-cycle while at 0x204.
    drive(0, 1, 32'h0, 1, 32'h10, 32'h200, 1);
    idle(6, 1);
    check("pre_async_pc", m_pc, 32'h204);
    #2 reset = 1'b1;
    #1;
    check("async_pc", pc, RST_PC);
    check("async_pc_valid", {31'b0, pc_valid}, 32'h0);
    check("async_pred_taken", {31'b0, pred_taken}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(6, 1);
    check("post_reset_no_hit", m_pc, 32'h18);

    // Randomized traffic in a small address window to provoke hits and aliases.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            {22'b0, 8'($urandom_range(0, 255)), 2'b00},
            $urandom_range(0, 4) == 0,
            {22'b0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
            {22'b0, 8'($urandom_range(0, 255)), 2'b00},
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
